multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, the maximum number of wait cycles allowed for mem_ready (used only with MEM_TIMEOUT_EN).
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 The block SHALL have port instr  input  16  instruction register contents; opcode = instr[15:12], funct = instr[2:0].
REQ-005 The block SHALL have port mem_ready  input  1  memory completes the current access this cycle.
REQ-006 The block SHALL have the following outputs, each 1 bit: mem_req (memory access request), pcwrite, irwrite, regwrite, regdst, alusrc, memtoreg, memwrite, branch, jump, halted, fault.
REQ-007 The block SHALL have port alucontrol  output  3  ALU operation select.

Function
REQ-008 The block SHALL implement states FETCH, DECODE, EXEC, MEM, WB and HALT, plus FAULT when MEM_TIMEOUT_EN is defined.
REQ-009 The block SHALL define opcodes as: 0000 R-type, 0001 addi, 0010 lw, 0011 sw, 0100 beq, 0101 j, 1111 halt.
REQ-010 FETCH SHALL assert mem_req, and SHALL stay in FETCH while mem_ready=0.
REQ-011 In a FETCH cycle with mem_ready=1, the block SHALL pulse irwrite=1 and pcwrite=1 for exactly that cycle, then go to DECODE.
REQ-012 DECODE SHALL last exactly one cycle, assert no datapath controls, and go to EXEC.
REQ-013 EXEC transitions SHALL be: R-type/addi -> WB; lw/sw -> MEM; beq -> FETCH with branch=1 for one cycle; j -> FETCH with jump=1 and pcwrite=1 for one cycle; halt or any undefined opcode -> HALT.
REQ-014 alucontrol SHALL equal funct for R-type, 010 (add) for addi/lw/sw, 110 (sub) for beq, and 000 otherwise.
REQ-015 alusrc SHALL be 1 for addi/lw/sw in the EXEC, MEM and WB states, and 0 otherwise.
REQ-016 MEM SHALL assert mem_req; for sw it SHALL also assert memwrite; it SHALL hold (with outputs held) while mem_ready=0.
REQ-017 In a MEM cycle with mem_ready=1, lw SHALL go to WB and sw SHALL go to FETCH.
REQ-018 WB SHALL assert regwrite for exactly one cycle, with regdst=1 for R-type and memtoreg=1 for lw, then go to FETCH.
REQ-019 With zero-wait memory, instruction latency SHALL be: R-type/addi/sw 4 cycles, lw 5 cycles, beq/j 3 cycles; each cycle of mem_ready=0 SHALL add one cycle.
REQ-020 HALT SHALL assert halted=1, hold all other control outputs at 0, and be left only by reset.
REQ-021 mem_ready asserted outside FETCH or MEM SHALL be ignored.
REQ-022 Every control output not explicitly asserted in a state SHALL be 0 in that state.

Reset
REQ-023 When reset=0 at a clock edge, the block SHALL enter FETCH, clear the wait counter, and drive all outputs 0 except mem_req, which SHALL be 1 in the first cycle after reset.
REQ-024 Reset SHALL take priority over every transition, including during a MEM wait and in HALT or FAULT, and SHALL abandon any in-flight access without a write pulse.

Configuration
REQ-025 When macro MULTICYCLE_CONTROL_MEM_TIMEOUT_EN is defined, a wait counter SHALL count consecutive mem_ready=0 cycles in FETCH or MEM, and SHALL clear when mem_ready=1 or when the state changes.
REQ-026 With the macro defined, once the counter reaches TIMEOUT the block SHALL go to FAULT, which asserts fault=1 and holds all other control outputs at 0 until reset.
REQ-027 When the macro is undefined, the counter and FAULT state SHALL NOT exist, fault SHALL be tied to 0, and waits SHALL be unbounded.

Structure
REQ-028 The block SHALL take the opcode enum, ALU operation constants and state enum from the shared package cpu_pkg.
REQ-029 The block SHALL contain one sub-module, control_decode: combinational mapping of opcode, funct and state to control outputs; the FSM and counter stay in multicycle_control.

Verification
REQ-030 Apply reset=0 for 2 cycles, then release -> the cycle after release shows FETCH, mem_req=1 and all other outputs 0.
REQ-031 Run instr 16'h72F1 (opcode 0111) with mem_ready tied to 1 -> irwrite pulses once, then after DECODE and EXEC halted=1, held for 10 or more cycles.
REQ-032 Run R-type funct=001 with mem_ready tied to 1 -> regwrite=1 and regdst=1 exactly on cycle 4 and alucontrol=001 during EXEC; then lw -> memtoreg=1 and regwrite=1 on cycle 5.
REQ-033 Run sw with mem_ready low for 3 MEM cycles -> memwrite=1 held for 4 cycles and instruction latency 7 cycles; run beq -> branch=1 for one cycle and alucontrol=110.
REQ-034 With MULTICYCLE_CONTROL_MEM_TIMEOUT_EN defined and TIMEOUT=15, hold mem_ready=0 in FETCH -> fault=1 after 15 wait cycles; without the macro -> still in FETCH after 100 cycles and fault=0.
REQ-035 Assert reset=0 during a lw MEM wait -> the next cycle shows FETCH with no regwrite or memwrite pulse.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcode, ALU-select and FSM-state definitions for the multicycle controller.
// S_FAULT exists only when MULTICYCLE_CONTROL_MEM_TIMEOUT_EN is defined.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_RTYPE = 4'b0000,
        OP_ADDI  = 4'b0001,
        OP_LW    = 4'b0010,
        OP_SW    = 4'b0011,
        OP_BEQ   = 4'b0100,
        OP_J     = 4'b0101,
        OP_HALT  = 4'b1111
    } opcode_t;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_NOP = 3'b000;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
`ifdef MULTICYCLE_CONTROL_MEM_TIMEOUT_EN
        , S_FAULT
`endif
    } state_t;

    // Instructions whose second ALU operand is the immediate.
    function automatic logic uses_imm(input logic [3:0] op);
        return (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic [2:0] alu_sel(input logic [3:0] op, input logic [2:0] funct);
        case (op)
            OP_RTYPE:            return funct;
            OP_ADDI, OP_LW, OP_SW: return ALU_ADD;
            OP_BEQ:              return ALU_SUB;
            default:             return ALU_NOP;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational control decode: (state, opcode, funct, mem_ready) -> control outputs.
// The fault output is only ever driven high when MULTICYCLE_CONTROL_MEM_TIMEOUT_EN is defined.
module control_decode
    import cpu_pkg::*;
(
    input  logic       active,
    input  state_t     state,
    input  logic [3:0] opcode,
    input  logic [2:0] funct,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       pcwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       alusrc,
    output logic       memtoreg,
    output logic       memwrite,
    output logic       branch,
    output logic       jump,
    output logic       halted,
    output logic       fault,
    output logic [2:0] alucontrol
);

    always_comb begin
        mem_req    = 1'b0;
        pcwrite    = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        alusrc     = 1'b0;
        memtoreg   = 1'b0;
        memwrite   = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        halted     = 1'b0;
        fault      = 1'b0;
        alucontrol = ALU_NOP;

        // While reset is held every output stays low, so an aborted access never writes.
        if (active) begin
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        irwrite = 1'b1;
                        pcwrite = 1'b1;
                    end
                end
                S_EXEC: begin
                    alusrc     = uses_imm(opcode);
                    alucontrol = alu_sel(opcode, funct);
                    if (opcode == OP_BEQ) begin
                        branch = 1'b1;
                    end
                    if (opcode == OP_J) begin
                        jump    = 1'b1;
                        pcwrite = 1'b1;
                    end
                end
                S_MEM: begin
                    mem_req    = 1'b1;
                    memwrite   = (opcode == OP_SW);
                    alusrc     = uses_imm(opcode);
                    alucontrol = alu_sel(opcode, funct);
                end
                S_WB: begin
                    regwrite   = 1'b1;
                    regdst     = (opcode == OP_RTYPE);
                    memtoreg   = (opcode == OP_LW);
                    alusrc     = uses_imm(opcode);
                    alucontrol = alu_sel(opcode, funct);
                end
                S_HALT: begin
                    halted = 1'b1;
                end
`ifdef MULTICYCLE_CONTROL_MEM_TIMEOUT_EN
                S_FAULT: begin
                    fault = 1'b1;
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT) with optional memory-wait
// timeout to a FAULT state, enabled by defining MULTICYCLE_CONTROL_MEM_TIMEOUT_EN.
module multicycle_control
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        pcwrite,
    output logic        irwrite,
    output logic        regwrite,
    output logic        regdst,
    output logic        alusrc,
    output logic        memtoreg,
    output logic        memwrite,
    output logic        branch,
    output logic        jump,
    output logic        halted,
    output logic        fault,
    output logic [2:0]  alucontrol
);

    state_t     state;
    state_t     state_next;
    logic [3:0] opcode;
    logic [2:0] funct;
    logic       unused_instr;
    logic       wait_hit;

    assign opcode       = instr[15:12];
    assign funct        = instr[2:0];
    assign unused_instr = ^instr[11:3];

`ifdef MULTICYCLE_CONTROL_MEM_TIMEOUT_EN
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_cnt;
    logic          waiting;

    // wait_cnt holds the number of earlier consecutive stalled cycles in this state.
    assign waiting  = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;
    assign wait_hit = waiting && (wait_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (waiting && (state_next == state)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end
`else
    logic unused_timeout;

    assign wait_hit       = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: begin
                if (mem_ready) begin
                    state_next = S_DECODE;
                end
`ifdef MULTICYCLE_CONTROL_MEM_TIMEOUT_EN
                else if (wait_hit) begin
                    state_next = S_FAULT;
                end
`endif
            end
            S_DECODE: state_next = S_EXEC;
            S_EXEC: begin
                case (opcode)
                    OP_RTYPE, OP_ADDI: state_next = S_WB;
                    OP_LW, OP_SW:      state_next = S_MEM;
                    OP_BEQ, OP_J:      state_next = S_FETCH;
                    default:           state_next = S_HALT;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_next = (opcode == OP_LW) ? S_WB : S_FETCH;
                end
`ifdef MULTICYCLE_CONTROL_MEM_TIMEOUT_EN
                else if (wait_hit) begin
                    state_next = S_FAULT;
                end
`endif
            end
            S_WB:   state_next = S_FETCH;
            S_HALT: state_next = S_HALT;
`ifdef MULTICYCLE_CONTROL_MEM_TIMEOUT_EN
            S_FAULT: state_next = S_FAULT;
`endif
            default: state_next = S_FETCH;
        endcase
    end

    control_decode u_decode (
        .active     (reset),
        .state      (state),
        .opcode     (opcode),
        .funct      (funct),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .pcwrite    (pcwrite),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .alusrc     (alusrc),
        .memtoreg   (memtoreg),
        .memwrite   (memwrite),
        .branch     (branch),
        .jump       (jump),
        .halted     (halted),
        .fault      (fault),
        .alucontrol (alucontrol)
    );

endmodule
